// File: rtl/ic74138_scan_seq_if.sv
// ic74138_scan_seq_if
//   Bundles the run controls and decoder-side outputs of ic74138_scan_seq.
//   master : run-request side (drives enable/oneshot/hold, observes status)
//   slave  : the sequencer itself
//   Signals:
//     enable_i      run request, level-sensitive
//     oneshot_i     1 = stop after the current frame
//     hold_i        freezes the dwell count while a line is enabled
//     skip_mask_i   [7:0] lines to skip (only with SCAN_SKIP_MASK_EN)
//     select_o      [2:0] decoder select lines
//     g1_o          decoder enable, active high
//     g2a_o/g2b_o   decoder enables, active low
//     frame_done_o  one-cycle pulse after the last line of a frame
//     busy_o        sequencer is not idle
//   Optional feature macro: SCAN_SKIP_MASK_EN
interface ic74138_scan_seq_if;
   logic       enable_i;
   logic       oneshot_i;
   logic       hold_i;
`ifdef SCAN_SKIP_MASK_EN
   logic [7:0] skip_mask_i;
`endif
   logic [2:0] select_o;
   logic       g1_o;
   logic       g2a_o;
   logic       g2b_o;
   logic       frame_done_o;
   logic       busy_o;

`ifdef SCAN_SKIP_MASK_EN
   modport master (
      output enable_i, oneshot_i, hold_i, skip_mask_i,
      input  select_o, g1_o, g2a_o, g2b_o, frame_done_o, busy_o
   );
   modport slave (
      input  enable_i, oneshot_i, hold_i, skip_mask_i,
      output select_o, g1_o, g2a_o, g2b_o, frame_done_o, busy_o
   );
`else
   modport master (
      output enable_i, oneshot_i, hold_i,
      input  select_o, g1_o, g2a_o, g2b_o, frame_done_o, busy_o
   );
   modport slave (
      input  enable_i, oneshot_i, hold_i,
      output select_o, g1_o, g2a_o, g2b_o, frame_done_o, busy_o
   );
`endif
endinterface

// File: rtl/ic74138_scan_seq.sv
// ic74138_scan_seq
//   Scan sequencer feeding a 74x138 3-to-8 decoder. Steps select through
//   lines 0..NUM_LINES-1; each line gets BLANK_CYCLES with the decoder
//   disabled (select already set up) followed by DWELL_CYCLES enabled.
//   All outputs are registered.
//   Ports:
//     clk_i  system clock, rising edge
//     rst_i  asynchronous active-high reset
//     bus    ic74138_scan_seq_if.slave (run controls, decoder pins, status)
//   Optional feature macro: SCAN_SKIP_MASK_EN adds bus.skip_mask_i; masked
//   lines are skipped entirely.
module ic74138_scan_seq #(
   parameter int unsigned NUM_LINES    = 8,
   parameter int unsigned DWELL_CYCLES = 4,
   parameter int unsigned BLANK_CYCLES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   ic74138_scan_seq_if.slave bus
);

   localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

   // A new line starts in BLANK, or directly enabled when there is no gap.
   localparam state_t ENTRY    = (BLANK_CYCLES == 0) ? ACTIVE : BLANK;
   localparam logic   ENTRY_EN = (BLANK_CYCLES == 0);

   state_t        state_q;
   logic [2:0]    sel_q;
   logic          g1_q, g2a_q, g2b_q;
   logic          fd_q;
   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic          stop_q;

   logic [7:0]    skip;
   logic          first_ok, next_ok, stopping, go_on;
   logic [2:0]    first_idx, next_idx, go_idx;

`ifdef SCAN_SKIP_MASK_EN
   assign skip = bus.skip_mask_i;
`else
   assign skip = '0;
`endif

   // Lowest usable line overall, and lowest usable line above the current one.
   always_comb begin
      first_ok  = 1'b0;
      first_idx = '0;
      next_ok   = 1'b0;
      next_idx  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < NUM_LINES && !skip[i]) begin
            if (!first_ok) begin
               first_ok  = 1'b1;
               first_idx = 3'(i);
            end
            if (!next_ok && i > 32'(sel_q)) begin
               next_ok  = 1'b1;
               next_idx = 3'(i);
            end
         end
      end
   end

   // A stop request seen at any point of the dwell is honoured at expiry.
   always_comb begin
      stopping = stop_q | ~bus.enable_i;
      go_on    = !stopping && (next_ok || (!bus.oneshot_i && first_ok));
      go_idx   = next_ok ? next_idx : first_idx;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         g1_q    <= 1'b0;
         g2a_q   <= 1'b1;
         g2b_q   <= 1'b1;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         fd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.enable_i && first_ok) begin
                  sel_q   <= first_idx;
                  cnt_q   <= '0;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ENTRY;
                  g1_q    <= ENTRY_EN;
                  g2a_q   <= ~ENTRY_EN;
                  g2b_q   <= ~ENTRY_EN;
               end
            end
            BLANK: begin
               if (!bus.enable_i) begin
                  state_q <= IDLE;
                  sel_q   <= '0;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  stop_q  <= 1'b0;
               end else if (cnt_q == BLANK_LAST) begin
                  state_q <= ACTIVE;
                  cnt_q   <= '0;
                  g1_q    <= 1'b1;
                  g2a_q   <= 1'b0;
                  g2b_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ACTIVE: begin
               if (!bus.enable_i) stop_q <= 1'b1;
               if (!bus.hold_i) begin
                  if (cnt_q == DWELL_LAST) begin
                     cnt_q <= '0;
                     // No usable line above this one: the frame ends here.
                     if (!next_ok) fd_q <= 1'b1;
                     if (go_on) begin
                        sel_q   <= go_idx;
                        state_q <= ENTRY;
                        g1_q    <= ENTRY_EN;
                        g2a_q   <= ~ENTRY_EN;
                        g2b_q   <= ~ENTRY_EN;
                     end else begin
                        state_q <= IDLE;
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        stop_q  <= 1'b0;
                        g1_q    <= 1'b0;
                        g2a_q   <= 1'b1;
                        g2b_q   <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               sel_q   <= '0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               stop_q  <= 1'b0;
               g1_q    <= 1'b0;
               g2a_q   <= 1'b1;
               g2b_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.select_o     = sel_q;
   assign bus.g1_o         = g1_q;
   assign bus.g2a_o        = g2a_q;
   assign bus.g2b_o        = g2b_q;
   assign bus.frame_done_o = fd_q;
   assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_ic74138_scan_seq.sv
// tb_ic74138_scan_seq
//   Two sequencers: A with defaults (8 lines, dwell 4, blank 1) and
//   B with 3 lines, dwell 2, no blank. A timeline model (elapsed active time
//   per line/frame) predicts every output each cycle; directed steps add
//   hand-computed literal expectations.
module tb_ic74138_scan_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ic74138_scan_seq_if bus_a ();
   ic74138_scan_seq_if bus_b ();

   ic74138_scan_seq #(.NUM_LINES(8), .DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_a)
   );

   ic74138_scan_seq #(.NUM_LINES(3), .DWELL_CYCLES(2), .BLANK_CYCLES(0)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: t is elapsed unheld time since start; line = t / period.
   typedef struct {
      bit run;
      int t;
      bit stop;
      bit fd;
   } model_t;

   function automatic model_t step(model_t m, int n, int b, int d, bit en, bit os, bit hold);
      model_t r;
      int p, pos, line;
      r = m;
      r.fd = 1'b0;
      p = b + d;
      if (!m.run) begin
         if (en) begin
            r.run  = 1'b1;
            r.t    = 0;
            r.stop = 1'b0;
         end
      end else begin
         pos  = m.t % p;
         line = (m.t / p) % n;
         if (pos < b) begin
            if (!en) r.run = 1'b0;
            else     r.t   = m.t + 1;
         end else begin
            if (!en) r.stop = 1'b1;
            if (!hold) begin
               if (pos == p - 1) begin
                  if (line == n - 1) r.fd = 1'b1;
                  if (r.stop || (line == n - 1 && os)) begin
                     r.run  = 1'b0;
                     r.stop = 1'b0;
                  end else begin
                     r.t = m.t + 1;
                  end
               end else begin
                  r.t = m.t + 1;
               end
            end
         end
      end
      return r;
   endfunction

   // {select[2:0], g1, g2a, g2b, frame_done, busy}
   function automatic logic [7:0] expect_out(model_t m, int n, int b, int d);
      int p, line;
      bit en;
      p = b + d;
      if (!m.run) return {3'd0, 1'b0, 1'b1, 1'b1, m.fd, 1'b0};
      line = (m.t / p) % n;
      en   = ((m.t % p) >= b);
      return {3'(line), en, ~en, ~en, m.fd, 1'b1};
   endfunction

   model_t ma = '{run: 1'b0, t: 0, stop: 1'b0, fd: 1'b0};
   model_t mb = '{run: 1'b0, t: 0, stop: 1'b0, fd: 1'b0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma = '{run: 1'b0, t: 0, stop: 1'b0, fd: 1'b0};
         mb = '{run: 1'b0, t: 0, stop: 1'b0, fd: 1'b0};
      end else begin
         ma = step(ma, 8, 1, 4, bus_a.enable_i, bus_a.oneshot_i, bus_a.hold_i);
         mb = step(mb, 3, 0, 2, bus_b.enable_i, bus_b.oneshot_i, bus_b.hold_i);
      end
   end

   always @(negedge clk) begin
      check("a_outputs",
            int'({bus_a.select_o, bus_a.g1_o, bus_a.g2a_o, bus_a.g2b_o, bus_a.frame_done_o, bus_a.busy_o}),
            int'(expect_out(ma, 8, 1, 4)));
      check("b_outputs",
            int'({bus_b.select_o, bus_b.g1_o, bus_b.g2a_o, bus_b.g2b_o, bus_b.frame_done_o, bus_b.busy_o}),
            int'(expect_out(mb, 3, 0, 2)));
   end

   // Observers for DUT A: frame_done spacing and enabled run length per line.
   int cyc = 0;
   int last_fd = -1;
   int fd_gap = 0;
   int fd_cnt = 0;
   int run_len = 0;
   int last_run [8];
   logic       prev_g1 = 1'b0;
   logic [2:0] prev_sel = '0;

   always @(negedge clk) begin
      cyc++;
      if (bus_a.frame_done_o) begin
         if (last_fd >= 0) fd_gap = cyc - last_fd;
         last_fd = cyc;
         fd_cnt++;
      end
      if (bus_a.g1_o) run_len = prev_g1 ? run_len + 1 : 1;
      else if (prev_g1) last_run[prev_sel] = run_len;
      prev_g1  = bus_a.g1_o;
      prev_sel = bus_a.select_o;
   end

   task automatic wait_line_a(input logic [2:0] s, input logic en, input string nm);
      int k = 0;
      while (!(bus_a.busy_o && bus_a.select_o == s && bus_a.g1_o == en) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(nm, int'(k < 200), 1);
   endtask

   task automatic check_reset_a(input string pfx);
      check({pfx, "_sel"},  int'(bus_a.select_o), 0);
      check({pfx, "_g1"},   int'(bus_a.g1_o), 0);
      check({pfx, "_g2a"},  int'(bus_a.g2a_o), 1);
      check({pfx, "_g2b"},  int'(bus_a.g2b_o), 1);
      check({pfx, "_fd"},   int'(bus_a.frame_done_o), 0);
      check({pfx, "_busy"}, int'(bus_a.busy_o), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int es_sel [8];
      int es_g1 [8];
      int es_fd [8];
      int es_busy [8];
      int k, fdc;

      bus_a.enable_i = 1'b0; bus_a.oneshot_i = 1'b0; bus_a.hold_i = 1'b0;
      bus_b.enable_i = 1'b0; bus_b.oneshot_i = 1'b0; bus_b.hold_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset_a("rst");
      rst = 1'b0;

      // Continuous scan on A.
      @(posedge clk); #1 bus_a.enable_i = 1'b1;
      @(negedge clk); check("start_idle_busy", int'(bus_a.busy_o), 0);
      @(negedge clk); check("start_blank", int'({bus_a.busy_o, bus_a.g1_o, bus_a.select_o}), 32'b1_0_000);
      @(negedge clk); check("start_active", int'({bus_a.busy_o, bus_a.g1_o, bus_a.select_o}), 32'b1_1_000);
      repeat (85) @(negedge clk);
      check("gap_continuous", fd_gap, 40);
      check("two_frames", int'(fd_cnt >= 2), 1);

      // Hold for 3 cycles starting on the 2nd enabled cycle of line 2.
      wait_line_a(3'd2, 1'b1, "wait_line2");
      @(posedge clk); #1 bus_a.hold_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus_a.hold_i = 1'b0;
      k = 0;
      while (!bus_a.frame_done_o && k < 100) begin @(negedge clk); k++; end
      check("wait_fd_hold", int'(k < 100), 1);
      @(negedge clk);
      check("line2_hold_len", last_run[2], 7);
      check("gap_hold", fd_gap, 43);

      // Drop enable on the 2nd enabled cycle of line 4.
      wait_line_a(3'd4, 1'b1, "wait_line4");
      last_run[4] = 0;
      fdc = fd_cnt;
      @(posedge clk); #1 bus_a.enable_i = 1'b0;
      repeat (12) @(negedge clk);
      check("line4_len", last_run[4], 4);
      check("line4_no_fd", fd_cnt, fdc);
      check("line4_idle", int'(bus_a.busy_o), 0);

      // Drop enable during the blank before line 3.
      @(posedge clk); #1 bus_a.enable_i = 1'b1;
      wait_line_a(3'd3, 1'b0, "wait_blank3");
      bus_a.enable_i = 1'b0;
      @(negedge clk);
      check("blank_drop", int'({bus_a.busy_o, bus_a.g1_o, bus_a.select_o}), 0);

      // Asynchronous reset while line 5 is enabled.
      @(posedge clk); #1 bus_a.enable_i = 1'b1;
      wait_line_a(3'd5, 1'b1, "wait_line5");
      #2 rst = 1'b1;
      #1 check_reset_a("async_rst");
      bus_a.enable_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // One-shot frame on B: 6 enabled cycles, then frame_done with busy low.
      es_sel  = '{0, 0, 1, 1, 2, 2, 0, 0};
      es_g1   = '{1, 1, 1, 1, 1, 1, 0, 1};
      es_fd   = '{0, 0, 0, 0, 0, 0, 1, 0};
      es_busy = '{1, 1, 1, 1, 1, 1, 0, 1};
      @(posedge clk); #1 bus_b.oneshot_i = 1'b1; bus_b.enable_i = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("os_sel%0d", i),  int'(bus_b.select_o), es_sel[i]);
         check($sformatf("os_g1%0d", i),   int'(bus_b.g1_o), es_g1[i]);
         check($sformatf("os_fd%0d", i),   int'(bus_b.frame_done_o), es_fd[i]);
         check($sformatf("os_busy%0d", i), int'(bus_b.busy_o), es_busy[i]);
      end
      @(posedge clk); #1 bus_b.enable_i = 1'b0;
      repeat (6) @(negedge clk);
      check("os_final_idle", int'(bus_b.busy_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
